// File: rtl/pmu_pkg.sv
// pmu_pkg: definitions shared by the PMU counter bank and the overflow monitor.
//   PMU_REG_WIDTH  - default counter width
//   PMU_N_COUNTERS - default number of counters in the bank
//   ovf_state_t    - overflow interrupt FSM states
package pmu_pkg;

  localparam int unsigned PMU_REG_WIDTH  = 32;
  localparam int unsigned PMU_N_COUNTERS = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } ovf_state_t;

endpackage

// File: rtl/pmu_overflow_if.sv
// pmu_overflow_if: signals between the PMU wrapper/counter bank (master) and the
// overflow monitor (slave).
//   en_i, we_i, counter_regs_i, events_i : taps of the counter bank controls/values
//   intr_mask_i, clear_i                 : software mask and write-1-to-clear
//   ovf_flags_o, intr_ovf_o              : sticky flags and overflow interrupt
//   first_idx_o, first_vld_o             : only when PMU_OVF_FIRST_IDX_EN is defined
interface pmu_overflow_if
  import pmu_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = PMU_REG_WIDTH,
  parameter int unsigned N_COUNTERS = PMU_N_COUNTERS
);

  logic                                 en_i;
  logic                                 we_i;
  logic [N_COUNTERS-1:0][REG_WIDTH-1:0] counter_regs_i;
  logic [N_COUNTERS-1:0]                events_i;
  logic [N_COUNTERS-1:0]                intr_mask_i;
  logic [N_COUNTERS-1:0]                clear_i;
  logic [N_COUNTERS-1:0]                ovf_flags_o;
  logic                                 intr_ovf_o;
`ifdef PMU_OVF_FIRST_IDX_EN
  localparam int unsigned IDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
  logic [IDX_W-1:0]                     first_idx_o;
  logic                                 first_vld_o;
`endif

  modport master (
    output en_i, we_i, counter_regs_i, events_i, intr_mask_i, clear_i,
`ifdef PMU_OVF_FIRST_IDX_EN
    input  first_idx_o, first_vld_o,
`endif
    input  ovf_flags_o, intr_ovf_o
  );

  modport slave (
    input  en_i, we_i, counter_regs_i, events_i, intr_mask_i, clear_i,
`ifdef PMU_OVF_FIRST_IDX_EN
    output first_idx_o, first_vld_o,
`endif
    output ovf_flags_o, intr_ovf_o
  );

endinterface

// File: rtl/pmu_ovf_slice.sv
// pmu_ovf_slice: per-counter overflow tracking.
// Ports: clk_i/rstn_i (async active-low), softrst_i, en_i, we_i, event_i,
//   clear_i, value_i (counter bank next value), flag_o (sticky overflow),
//   wrap_o (only with PMU_OVF_FIRST_IDX_EN).
// The shadow tracks the counter bank register, so a wrap is a counted event
// while the current count is all-ones.
module pmu_ovf_slice #(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 softrst_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic                 event_i,
  input  logic                 clear_i,
  input  logic [REG_WIDTH-1:0] value_i,
`ifdef PMU_OVF_FIRST_IDX_EN
  output logic                 wrap_o,
`endif
  output logic                 flag_o
);

  logic [REG_WIDTH-1:0] shadow_d, shadow_q;
  logic                 flag_d, flag_q;
  logic                 wrap_s;

  // Write cycles load the counter and therefore never count as a wrap.
  assign wrap_s = en_i & ~we_i & ~softrst_i & event_i &
                  (shadow_q == {REG_WIDTH{1'b1}});

  // Next-state for shadow and sticky flag; a set beats a same-cycle clear.
  always_comb begin
    shadow_d = shadow_q;
    flag_d   = flag_q;
    if (softrst_i) begin
      shadow_d = {REG_WIDTH{1'b0}};
      flag_d   = 1'b0;
    end else begin
      shadow_d = value_i;
      flag_d   = wrap_s | (flag_q & ~clear_i);
    end
  end

  // Shadow and flag registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow_q <= {REG_WIDTH{1'b0}};
      flag_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      flag_q   <= flag_d;
    end
  end

  assign flag_o = flag_q;
`ifdef PMU_OVF_FIRST_IDX_EN
  assign wrap_o = wrap_s;
`endif

endmodule

// File: rtl/pmu_overflow.sv
// pmu_overflow: counter wrap-around monitor with sticky flags and one maskable,
// level-sensitive overflow interrupt.
// Ports: clk_i, rstn_i (async active-low), softrst_i (sync, highest priority),
//   bus (pmu_overflow_if.slave): bank taps, mask, clear, flags, interrupt.
// Optional macro PMU_OVF_FIRST_IDX_EN adds first_idx_o/first_vld_o on the bus:
//   lowest index of the counter(s) that wrapped while no flag was set.
module pmu_overflow
  import pmu_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = PMU_REG_WIDTH,
  parameter int unsigned N_COUNTERS = PMU_N_COUNTERS
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           softrst_i,
  pmu_overflow_if.slave  bus
);

  logic [N_COUNTERS-1:0] flags_s;
  logic                  pend_s;
  ovf_state_t            state_d, state_q;
  logic                  intr_d, intr_q;
`ifdef PMU_OVF_FIRST_IDX_EN
  localparam int unsigned IDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
  logic [N_COUNTERS-1:0] wrap_s;
  logic [IDX_W-1:0]      low_idx_s, first_idx_d, first_idx_q;
  logic                  first_vld_d, first_vld_q;
`endif

  for (genvar k = 0; k < N_COUNTERS; k++) begin : g_slice
    pmu_ovf_slice #(.REG_WIDTH(REG_WIDTH)) u_slice (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .softrst_i (softrst_i),
      .en_i      (bus.en_i),
      .we_i      (bus.we_i),
      .event_i   (bus.events_i[k]),
      .clear_i   (bus.clear_i[k]),
      .value_i   (bus.counter_regs_i[k]),
`ifdef PMU_OVF_FIRST_IDX_EN
      .wrap_o    (wrap_s[k]),
`endif
      .flag_o    (flags_s[k])
    );
  end

  assign pend_s = |(flags_s & bus.intr_mask_i);

  // Interrupt FSM next state; the output is registered from the next state
  // so it changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    if (softrst_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = pend_s ? PEND : IDLE;
        PEND:    state_d = pend_s ? PEND : IDLE;
        default: state_d = IDLE;
      endcase
    end
    intr_d = (state_d == PEND);
  end

  // Interrupt FSM state and output register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
    end
  end

  assign bus.ovf_flags_o = flags_s;
  assign bus.intr_ovf_o  = intr_q;

`ifdef PMU_OVF_FIRST_IDX_EN
  // Lowest set wrap bit: scanning downward lets the lowest index win.
  always_comb begin
    low_idx_s = {IDX_W{1'b0}};
    for (int k = int'(N_COUNTERS) - 1; k >= 0; k--) begin
      low_idx_s = wrap_s[k] ? IDX_W'(k) : low_idx_s;
    end
  end

  // Capture only while no flag is set; valid drops once all flags are clear.
  always_comb begin
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    if (softrst_i) begin
      first_idx_d = {IDX_W{1'b0}};
      first_vld_d = 1'b0;
    end else if (flags_s == {N_COUNTERS{1'b0}}) begin
      if (|wrap_s) begin
        first_idx_d = low_idx_s;
        first_vld_d = 1'b1;
      end else begin
        first_vld_d = 1'b0;
      end
    end else begin
      first_vld_d = first_vld_q;
    end
  end

  // First-index registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      first_idx_q <= {IDX_W{1'b0}};
      first_vld_q <= 1'b0;
    end else begin
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign bus.first_idx_o = first_idx_q;
  assign bus.first_vld_o = first_vld_q;
`endif

endmodule

// File: tb/tb_pmu_overflow.sv
// Directed, table-driven bench for pmu_overflow (9 counters x 32 bits).
// Each vector drives one cycle of inputs; the outputs are compared 1 ns after
// the following rising edge. Counter values are either all-ones or zero.
module tb_pmu_overflow;

  localparam int unsigned RW = 32;
  localparam int unsigned NC = 9;

  typedef struct {
    logic          en;
    logic          we;
    logic [NC-1:0] ones;
    logic [NC-1:0] ev;
    logic [NC-1:0] mask;
    logic [NC-1:0] clr;
    logic [NC-1:0] exp_flags;
    logic          exp_intr;
  } vec_t;

  logic clk_i = 1'b0;
  logic rstn_i;
  logic softrst_i;
  int   checks = 0;
  int   passed = 0;
  vec_t vecs[$];

  pmu_overflow_if #(.REG_WIDTH(RW), .N_COUNTERS(NC)) bus ();

  pmu_overflow #(.REG_WIDTH(RW), .N_COUNTERS(NC)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .softrst_i (softrst_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic en, input logic we, input logic [NC-1:0] ones,
                              input logic [NC-1:0] ev, input logic [NC-1:0] mask,
                              input logic [NC-1:0] clr, input logic [NC-1:0] ef,
                              input logic ei);
    vec_t v;
    v.en = en; v.we = we; v.ones = ones; v.ev = ev; v.mask = mask;
    v.clr = clr; v.exp_flags = ef; v.exp_intr = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic we, input logic [NC-1:0] ones,
                       input logic [NC-1:0] ev, input logic [NC-1:0] mask,
                       input logic [NC-1:0] clr);
    bus.en_i        = en;
    bus.we_i        = we;
    bus.events_i    = ev;
    bus.intr_mask_i = mask;
    bus.clear_i     = clr;
    for (int k = 0; k < int'(NC); k++)
      bus.counter_regs_i[k] = ones[k] ? 32'hFFFF_FFFF : 32'h0000_0000;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Load all counters with all-ones, wrap them all, then let the interrupt rise.
  task automatic setup_all(input string tag);
    drive(1'b0, 1'b1, 9'h1FF, 9'h000, 9'h1FF, 9'h000); tick();
    drive(1'b1, 1'b0, 9'h000, 9'h1FF, 9'h1FF, 9'h000); tick();
    drive(1'b0, 1'b1, 9'h1FF, 9'h000, 9'h1FF, 9'h000); tick();
    chk({tag, " flags"}, 32'(bus.ovf_flags_o), 32'h1FF);
    chk({tag, " intr"},  32'(bus.intr_ovf_o),  32'h1);
  endtask

  initial begin
    rstn_i    = 1'b0;
    softrst_i = 1'b0;
    drive(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000);
    #12;
    chk("reset flags", 32'(bus.ovf_flags_o), 32'h0);
    chk("reset intr",  32'(bus.intr_ovf_o),  32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();

    //                en    we    ones    ev      mask    clr     flags   intr
    vecs.push_back(mk(1'b0, 1'b1, 9'h001, 9'h000, 9'h1FF, 9'h000, 9'h000, 1'b0)); // load c0
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h001, 9'h1FF, 9'h000, 9'h001, 1'b0)); // c0 wraps
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000, 9'h001, 1'b1)); // intr +2
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h001, 9'h000, 1'b1)); // clear
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000, 9'h000, 1'b0)); // intr low
    vecs.push_back(mk(1'b0, 1'b1, 9'h001, 9'h000, 9'h1FF, 9'h000, 9'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h001, 9'h1FF, 9'h000, 9'h001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h001, 9'h000, 9'h1FF, 9'h000, 9'h001, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h001, 9'h1FF, 9'h001, 9'h001, 1'b1)); // set wins
    vecs.push_back(mk(1'b0, 1'b1, 9'h001, 9'h000, 9'h1FF, 9'h000, 9'h001, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h001, 9'h1FF, 9'h000, 9'h001, 1'b1)); // 2nd wrap
    vecs.push_back(mk(1'b0, 1'b1, 9'h008, 9'h000, 9'h1FF, 9'h000, 9'h001, 1'b1)); // load c3
    vecs.push_back(mk(1'b1, 1'b1, 9'h000, 9'h008, 9'h1FF, 9'h000, 9'h001, 1'b1)); // write, no flag
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h008, 9'h1FF, 9'h000, 9'h001, 1'b1)); // shadow is 0
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h001, 9'h000, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000, 9'h000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h020, 9'h000, 9'h000, 9'h000, 9'h000, 1'b0)); // load c5
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h020, 9'h000, 9'h000, 9'h020, 1'b0)); // masked wrap
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h020, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h020, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h020, 9'h000, 9'h020, 1'b1)); // unmask
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h020, 1'b0)); // re-mask
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000, 9'h020, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 9'h010, 9'h000, 9'h1FF, 9'h000, 9'h020, 1'b1)); // load c4
    vecs.push_back(mk(1'b0, 1'b0, 9'h010, 9'h010, 9'h1FF, 9'h000, 9'h020, 1'b1)); // en=0
    vecs.push_back(mk(1'b0, 1'b0, 9'h010, 9'h000, 9'h1FF, 9'h020, 9'h000, 1'b1)); // clear, en=0
    vecs.push_back(mk(1'b0, 1'b0, 9'h010, 9'h000, 9'h1FF, 9'h000, 9'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h000, 9'h010, 9'h1FF, 9'h000, 9'h010, 1'b0)); // c4 wraps
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h010, 9'h000, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000, 9'h000, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].ones, vecs[i].ev, vecs[i].mask, vecs[i].clr);
      tick();
      chk($sformatf("vec%0d flags", i), 32'(bus.ovf_flags_o), 32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d intr", i),  32'(bus.intr_ovf_o),  32'(vecs[i].exp_intr));
    end

    // Soft reset beats a simultaneous wrap on every counter.
    setup_all("pre-softrst");
    softrst_i = 1'b1;
    drive(1'b1, 1'b0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000); tick();
    softrst_i = 1'b0;
    chk("softrst flags", 32'(bus.ovf_flags_o), 32'h0);
    chk("softrst intr",  32'(bus.intr_ovf_o),  32'h0);
    drive(1'b1, 1'b0, 9'h000, 9'h1FF, 9'h1FF, 9'h000); tick();
    chk("softrst shadow cleared", 32'(bus.ovf_flags_o), 32'h0);

    // Asynchronous reset mid-cycle clears without a clock edge.
    setup_all("pre-rstn");
    drive(1'b1, 1'b0, 9'h000, 9'h1FF, 9'h1FF, 9'h000);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("async rst flags", 32'(bus.ovf_flags_o), 32'h0);
    chk("async rst intr",  32'(bus.intr_ovf_o),  32'h0);
    #1;
    rstn_i = 1'b1;
    tick();
    chk("async rst shadow cleared", 32'(bus.ovf_flags_o), 32'h0);

`ifdef PMU_OVF_FIRST_IDX_EN
    drive(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000); tick();
    chk("first vld idle", 32'(bus.first_vld_o), 32'h0);
    drive(1'b0, 1'b1, 9'h084, 9'h000, 9'h1FF, 9'h000); tick();
    drive(1'b1, 1'b0, 9'h000, 9'h084, 9'h1FF, 9'h000); tick();
    chk("first flags", 32'(bus.ovf_flags_o), 32'h084);
    chk("first idx",   32'(bus.first_idx_o), 32'h2);
    chk("first vld",   32'(bus.first_vld_o), 32'h1);
    drive(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h004); tick();
    chk("first idx after clr2", 32'(bus.first_idx_o), 32'h2);
    chk("first vld after clr2", 32'(bus.first_vld_o), 32'h1);
    drive(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h080); tick();
    drive(1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 9'h000); tick();
    chk("first vld after clr7", 32'(bus.first_vld_o), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pmu_overflow.md
Name: pmu_overflow

Overview:
- Sits directly downstream of the PMU event-counter bank.
- Taps the counter bank's output value bus, plus the same events, enable, soft-reset and write-enable signals.
- Detects per-counter wrap-around (all-ones to zero) and keeps sticky, software-clearable overflow flags.
- Raises one maskable overflow interrupt toward the PMU wrapper, so software knows a count has been lost.

Parameters:
- REG_WIDTH, 32, width of each counter value.
- N_COUNTERS, 9, number of counters monitored; must match the counter bank.

Ports:
- clk_i  in  1  single clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- softrst_i  in  1  soft reset from the configuration register; active high.
- en_i  in  1  PMU enable; same signal that drives the counter bank.
- we_i  in  1  counter bank write-enable; high while the wrapper loads counter values.
- counter_regs_i  in  [REG_WIDTH-1:0] x N_COUNTERS  counter bank output bus; carries the next-cycle counter values.
- events_i  in  N_COUNTERS  SoC event bits fed to the counter bank.
- intr_mask_i  in  N_COUNTERS  per-counter interrupt enable; 1 = enabled.
- clear_i  in  N_COUNTERS  write-1-to-clear pulses for the overflow flags.
- ovf_flags_o  out  N_COUNTERS  sticky overflow flags.
- intr_ovf_o  out  1  registered overflow interrupt; level-sensitive.

Behaviour:
- Reset: rstn_i low asynchronously forces shadow[k]=0, ovf_flags_o=0, intr_ovf_o=0 and FSM=IDLE.
- Shadow: one register per counter, shadow[k] <= counter_regs_i[k] every cycle, so it always equals the counter bank's internal register.
- Soft reset: softrst_i high forces shadow=0, flags=0, FSM=IDLE and intr_ovf_o=0 on the next edge. It has priority over every other input.
- Wrap detect (combinational): wrap[k] = en_i & ~we_i & ~softrst_i & events_i[k] & (shadow[k] == all-ones).
- A write cycle (we_i=1) never flags. The shadow loads the written value that same cycle.
- Flag update: flag[k] <= wrap[k] | (flag[k] & ~clear_i[k]).
  - A set and a clear in the same cycle: set wins, so no overflow is lost.
  - Latency: flag is visible 1 cycle after the edge on which the counter wrapped.
- No counting of repeat overflows. A second wrap while the flag is already set leaves the flag at 1.
- Interrupt FSM, two states; the transition is taken on the edge after the condition:
  - IDLE -> PEND when |(flags & intr_mask_i).
  - PEND -> IDLE when (flags & intr_mask_i)==0, either because the flag was cleared or because it was masked.
- intr_ovf_o = (state==PEND), registered.
  - Latency from the wrap edge to intr_ovf_o high: 2 cycles.
  - Latency from the clearing clear_i edge to intr_ovf_o low: 2 cycles.
- Masked flags still set and read back; they only stop driving the interrupt.
- en_i=0: no detection. Flags and FSM hold their state and can still be cleared.

Optional Feature:
- Macro PMU_OVF_FIRST_IDX_EN.
- When defined, add output first_idx_o, width $clog2(N_COUNTERS), and a valid bit first_vld_o.
  - On the first flag set while all flags are 0, capture the index of the counter that wrapped. If several wrap together, capture the lowest index.
  - Valid holds until all flags are 0, then drops the next cycle.
  - Both outputs reset to 0.
- When not defined: no extra ports and no extra logic.

Decomposition:
- Shared package pmu_pkg:
  - ovf_state_t enum {IDLE, PEND}.
  - Default constants for REG_WIDTH and N_COUNTERS, shared with the counter bank.
- Sub-module pmu_ovf_slice: one per counter, generated N_COUNTERS times; holds the shadow, the wrap detect and the flag.
- Top level holds the interrupt FSM and the optional first-index logic.

Test Plan:
- Wrap: load counter 0 with 0xFFFFFFFF via we_i, then en_i=1 and events_i[0]=1 for one cycle; mask=all-ones.
  - Expect counter_regs_i[0]=0 and flags=0x001 one cycle later.
  - Expect intr_ovf_o=1 two cycles after the wrap.
- Clear: clear_i=0x001 for one cycle.
  - Expect flags=0 next cycle and intr_ovf_o=0 one cycle after that.
  - Repeat with a new wrap on counter 0 in the same cycle as the clear; expect the flag to stay 1.
- Write masking: we_i=1 with regs_i[3]=0 while shadow[3]=0xFFFFFFFF and events_i[3]=1.
  - Expect no flag. The shadow reads 0.
- Mask: counter 5 wraps with mask=0x000.
  - Expect flags=0x020 and intr_ovf_o held at 0.
  - Set mask=0x020; expect intr_ovf_o=1 after 1 cycle.
- Resets: with flags=0x1FF and intr_ovf_o=1:
  - Pulse softrst_i; expect everything 0 on the next edge.
  - Repeat the setup, then drop rstn_i mid-cycle; expect immediate clear without waiting for a clock edge.
- PMU_OVF_FIRST_IDX_EN build: counters 2 and 7 wrap in the same cycle.
  - Expect first_idx_o=2 and first_vld_o=1.
  - Clear 2 only: index stays 2. Clear 7: first_vld_o=0.
